// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding, default MISR taps/seed and the
// signature width shared with the pattern generator.
package bist_pkg;

   localparam int         MISR_WIDTH   = 8;
   localparam logic [7:0] DEFAULT_POLY = 8'h1D;  // x^8+x^4+x^3+x^2+1
   localparam logic [7:0] DEFAULT_SEED = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SKIP     = 3'd1,
      ST_COMPRESS = 3'd2,
      ST_COMPARE  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/misr_core.sv
// WIDTH-bit multiple-input signature register: synchronous load of SEED,
// shift with POLY feedback XORed with the parallel input when enabled.
module misr_core #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] feedback;

   // Feedback taps apply only when the bit shifted out is set.
   always_comb begin
      feedback = sig[WIDTH-1] ? POLY : '0;
   end

   // Signature register; load takes priority over a compression step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sig <= SEED;
      else if (load)
         sig <= SEED;
      else if (enable)
         sig <= {sig[WIDTH-2:0], 1'b0} ^ feedback ^ data;
   end

endmodule

// File: rtl/bist_misr_analyzer.sv
// Output response analyzer: compresses N_PATTERNS valid products into a MISR,
// then compares against GOLDEN and reports done/pass.
// Optional feature macro: BIST_LATENCY_SKIP_EN (discard the first LATENCY
// valid samples of each run to flush upstream pipeline fill values).
module bist_misr_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH      = MISR_WIDTH,
   parameter int               N_PATTERNS = 15,
   parameter logic [WIDTH-1:0] POLY       = DEFAULT_POLY,
   parameter logic [WIDTH-1:0] SEED       = DEFAULT_SEED,
   parameter logic [WIDTH-1:0] GOLDEN     = 8'h00,
   parameter int               LATENCY    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int CW = $clog2(N_PATTERNS + 1);

`ifdef BIST_LATENCY_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   // State entered from an accepted start.
   localparam state_t FIRST_STATE = (SKIP_EN && LATENCY > 0) ? ST_SKIP : ST_COMPRESS;

   state_t        state, state_next;
   logic [CW-1:0] count;
   logic          load, shift, finish;
   logic          count_last;

   assign count_last = (count == CW'(N_PATTERNS - 1));

`ifdef BIST_LATENCY_SKIP_EN
   localparam int SW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   logic [SW-1:0] skip_cnt;
   logic          skip_inc;
   logic          skip_last;

   assign skip_last = (skip_cnt == SW'(LATENCY - 1));

   // Counts discarded samples during SKIP; cleared on every accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         skip_cnt <= '0;
      else if (load)
         skip_cnt <= '0;
      else if (skip_inc)
         skip_cnt <= skip_cnt + 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic and single-cycle control strobes.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
`ifdef BIST_LATENCY_SKIP_EN
      skip_inc   = 1'b0;
`endif
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = FIRST_STATE;
            end
         end
`ifdef BIST_LATENCY_SKIP_EN
         ST_SKIP: begin
            if (data_valid) begin
               skip_inc = 1'b1;
               if (skip_last)
                  state_next = ST_COMPRESS;
            end
         end
`endif
         ST_COMPRESS: begin
            if (data_valid) begin
               shift = 1'b1;
               if (count_last)
                  state_next = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            finish     = 1'b1;
            state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Accepted-sample counter; never wraps because COMPRESS exits at N_PATTERNS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= '0;
      else if (shift)
         count <= count + 1'b1;
   end

   // Status flags: cleared on start, resolved in the COMPARE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
      end else if (load) begin
         busy <= 1'b1;
         done <= 1'b0;
         pass <= 1'b0;
      end else if (finish) begin
         busy <= 1'b0;
         done <= 1'b1;
         pass <= (signature == GOLDEN);
      end
   end

   misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .enable (shift),
      .data   (data_in),
      .sig    (signature)
   );

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Scoreboard bench for bist_misr_analyzer: the driver pushes the expected
// final result of each run; a negedge monitor pops it when done rises.
module tb_bist_misr_analyzer;

   localparam int         N      = 4;
   localparam logic [7:0] POLY   = 8'h1D;
   localparam logic [7:0] SEED   = 8'h00;
   localparam logic [7:0] GOLDEN = 8'hC3;
   localparam int         LAT    = 1;
`ifdef BIST_LATENCY_SKIP_EN
   localparam int SKIPN = LAT;
`else
   localparam int SKIPN = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       data_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       busy, done, pass;
   logic [7:0] signature;

   bist_misr_analyzer #(
      .WIDTH(8), .N_PATTERNS(N), .POLY(POLY), .SEED(SEED),
      .GOLDEN(GOLDEN), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .data_valid(data_valid),
      .data_in(data_in), .busy(busy), .done(done), .pass(pass),
      .signature(signature)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] sig;
      logic       pass;
      int         done_edge;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: polynomial multiply-by-x modulo the MISR polynomial, plus the
   // sample. Returns the stream index that completes the run (-1 if short).
   function automatic int model(input logic [7:0] smp[$], output logic [7:0] sig);
      int v;
      int taken;
      taken = 0;
      sig   = SEED;
      for (int i = 0; i < smp.size(); i++) begin
         if (i < SKIPN) continue;
         v = int'(sig) * 2;
         if (v >= 256) v = v ^ (256 | int'(POLY));
         sig = 8'(v) ^ smp[i];
         taken++;
         if (taken == N) return i;
      end
      return -1;
   endfunction

   // Monitor: every rising done must match the oldest expected run.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (reset && done && !done_q) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no run pending");
         end else begin
            e = sbq.pop_front();
            chk("final_signature", 32'(signature), 32'(e.sig));
            chk("final_pass",      32'(pass),      32'(e.pass));
            chk("busy_at_done",    32'(busy),      32'd0);
            chk("done_edge",       32'(cyc),       32'(e.done_edge));
         end
      end
      done_q = done;
   end

   // One run: start pulse, then the stream with random idle gaps; optional
   // extra start pulses inside gaps (busy, so they must be ignored).
   task automatic run(input logic [7:0] smp[$], input int gap_max, input bit extra_start);
      logic [7:0] es;
      int         last_idx;
      int         t;
      last_idx = model(smp, es);
      chk("stream_completes_run", 32'(last_idx >= 0), 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy",   32'(busy),      32'd1);
      chk("start_done",   32'(done),      32'd0);
      chk("start_sigseed", 32'(signature), 32'(SEED));
      for (int i = 0; i < smp.size(); i++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            if (extra_start && ($urandom_range(1, 0) == 1)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         data_valid = 1'b1;
         data_in    = smp[i];
         @(posedge clk); #1;
         data_valid = 1'b0;
         data_in    = 8'($urandom);
         if (i == last_idx) sbq.push_back('{es, es == GOLDEN, cyc + 1});
      end
      t = 0;
      while (sbq.size() != 0 && t < 40) begin
         @(posedge clk);
         t++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 40 cycles");
         sbq.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] q[$];

      // Reset held for 5 cycles.
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_sig",  32'(signature), 32'h00);
      reset = 1'b1;
      @(posedge clk); #1;

      // Golden run: 4 x 0x15 -> C3, pass.
      q = {8'h15, 8'h15, 8'h15, 8'h15};
      repeat (SKIPN) q.push_front(8'($urandom));
      run(q, 0, 1'b0);

      // Fail detection: third sample 0x16.
      q = {8'h15, 8'h15, 8'h16, 8'h15};
      repeat (SKIPN) q.push_front(8'($urandom));
      run(q, 0, 1'b0);

      // Valid gaps: same golden stream with idle cycles.
      q = {8'h15, 8'h15, 8'h15, 8'h15};
      repeat (SKIPN) q.push_front(8'($urandom));
      run(q, 3, 1'b0);

      // Skip stream: 00 then 4 x 15 (pass only when the skip is built).
      q = {8'h00, 8'h15, 8'h15, 8'h15, 8'h15};
      run(q, 0, 1'b0);

      // start while busy is ignored.
      q = {8'h15, 8'h15, 8'h15, 8'h15};
      repeat (SKIPN) q.push_front(8'($urandom));
      run(q, 2, 1'b1);

      // Reset mid-COMPRESS: async, checked without a clock edge.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (SKIPN + 2) begin
         data_valid = 1'b1;
         data_in    = 8'h5A;
         @(posedge clk); #1;
      end
      data_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_pass", 32'(pass), 32'd0);
      chk("midrst_sig",  32'(signature), 32'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Randomized runs.
      for (int r = 0; r < 20; r++) begin
         q = {};
         for (int k = 0; k < N + SKIPN; k++) q.push_back(8'($urandom));
         if (r % 5 == 0) begin
            q = {8'h15, 8'h15, 8'h15, 8'h15};
            repeat (SKIPN) q.push_front(8'($urandom));
         end
         run(q, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_misr_analyzer.md
# bist_misr_analyzer

Output response analyzer for the BIST datapath. It sits directly downstream of the radix multiplier and compresses the multiplier's 8-bit product stream into a multiple-input signature register (MISR) over a fixed number of patterns. It then compares the final signature against a golden constant and reports pass/fail to the BIST controller.

## Interface
- WIDTH, 8, product/signature width (matches multiplier `out`)
- N_PATTERNS, 15, number of valid samples compressed (≥1)
- POLY, 8'h1D, MISR feedback taps (x^8+x^4+x^3+x^2+1)
- SEED, 8'h00, signature value loaded on start
- GOLDEN, 8'h00, expected final signature
- LATENCY, 1, valid samples discarded before compression (used only with BIST_LATENCY_SKIP_EN)

- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle pulse; begins a run when idle
- data_valid  input  1  data_in holds a product to compress this cycle
- data_in  input  WIDTH  multiplier product (`out` of the upstream stage)
- busy  output  1  run in progress
- done  output  1  run finished; held until the next accepted start
- pass  output  1  final signature == GOLDEN; qualified by done
- signature  output  WIDTH  current MISR contents

## Operation
- States: IDLE, SKIP (macro only), COMPRESS, COMPARE, DONE.
- IDLE/DONE + start: signature<=SEED, count<=0, done<=0, pass<=0, busy<=1. Go to SKIP if macro enabled and LATENCY>0, else COMPRESS.
- SKIP: each data_valid increments skip counter; after LATENCY valid samples go to COMPRESS. Data is discarded and signature is unchanged.
- COMPRESS: on data_valid, sig <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ data_in; count++. Cycles without data_valid hold the signature. The valid sample that brings count to N_PATTERNS moves to COMPARE.
- COMPARE (1 cycle): pass<=(signature==GOLDEN), done<=1, busy<=0, go to DONE.
- DONE: outputs hold; start re-arms as above.
- start while busy: ignored. data_valid in IDLE/DONE: ignored.
- Count is an internal counter of width $clog2(N_PATTERNS+1); no wrap within a run.

## Timing
- Reset (async assert, synchronous release): state=IDLE, busy=0, done=0, pass=0, signature=SEED, counters=0.
- Reset mid-run aborts immediately; no partial result is reported.
- start at edge k -> busy=1 after edge k; the first sample is accepted at edge k+1.
- Last valid sample at edge m -> state COMPARE after m. At edge m+1, done=1, pass valid, busy=0.
- Minimum run, no skip: N_PATTERNS+2 cycles from start to done.
- signature updates one cycle after each accepted sample; it is registered with no combinational path from data_in.

## Configuration
- BIST_LATENCY_SKIP_EN defined: SKIP state and skip counter are built. The first LATENCY valid samples after start are discarded, which flushes pipeline fill values from the upstream multiplier.
- Not defined: no SKIP state. Compression starts with the first valid sample after start, and LATENCY is unused.

## Structure
- Shared package bist_pkg holds the state enum/localparams, the default POLY and SEED, and the MISR width constant shared with the pattern generator.
- One natural sub-module: misr_core (the WIDTH-bit shift/feedback register with load/enable), reused by the stimulus-side LFSR checks. FSM and counters stay in bist_misr_analyzer.

## Test plan
- Reset behaviour: hold reset=0 for 5 cycles -> busy=0, done=0, pass=0, signature=8'h00. Assert reset mid-COMPRESS -> same values with no clock edge needed.
- Golden pass (N_PATTERNS=4, SEED=0, GOLDEN=8'hC3, macro off): start, then 4 valid cycles of data_in=8'h15 (7×3) -> signature steps 15,3F,6B,C3; done=1, pass=1 exactly 6 cycles after start.
- Fail detection: same setup, third sample 8'h16 -> signature ≠ C3; done=1, pass=0.
- Valid gaps: interleave data_valid=0 cycles between the 4 samples -> identical final signature C3; done is delayed by the gap count.
- Skip (macro on, LATENCY=1): first valid sample 8'h00 then 4×8'h15 -> pass=1. The same stream with the macro off -> pass=0.
- Protocol: start pulsed while busy -> ignored, and the run completes normally. start in DONE -> done clears the next cycle and signature reloads SEED.
